// File: rtl/cpu_pkg.sv
// Shared types and constants for the write-back stage of the 16-bit CPU.
package cpu_pkg;

  // Result source chosen when an instruction enters the WB stage.
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC   = 2'b10,
    WB_SEL_BYTE = 2'b11
  } wb_sel_e;

  // Register 0 reads as zero and is never written.
  localparam logic [3:0] REG_ZERO = 4'h0;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB instruction bundle: the MEM stage drives it, the WB stage consumes it.
interface wb_stage_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             mem_valid;
  logic             mem_wb_en;
  logic [AW-1:0]    mem_dst;
  wb_sel_e          mem_sel;
  logic             mem_byte_hi;
  logic [WIDTH-1:0] mem_alu_res;
  logic [WIDTH-1:0] mem_load_data;
  logic [WIDTH-1:0] mem_pc_next;
  logic [WIDTH-1:0] mem_old_dst;
  logic [7:0]       mem_imm8;
  logic             mem_halt;

  modport master (
    output mem_valid, mem_wb_en, mem_dst, mem_sel, mem_byte_hi,
           mem_alu_res, mem_load_data, mem_pc_next, mem_old_dst,
           mem_imm8, mem_halt
  );

  modport slave (
    input  mem_valid, mem_wb_en, mem_dst, mem_sel, mem_byte_hi,
           mem_alu_res, mem_load_data, mem_pc_next, mem_old_dst,
           mem_imm8, mem_halt
  );
endinterface

// File: rtl/wb_stage_result_mux.sv
// Result select for the WB stage: ALU, load data, PC+2, or LLB/LHB byte merge.
module wb_result_mux
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wb_sel_e          sel,
  input  logic             byte_hi,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] pc_next,
  input  logic [WIDTH-1:0] old_dst,
  input  logic [7:0]       imm8,
  output logic [WIDTH-1:0] result
);

  // Pick the write-back value; byte merge replaces one byte of the old destination.
  always_comb begin
    // NOTE: default first so every path assigns result and no latch is inferred.
    result = alu_res;
    case (sel)
      WB_SEL_ALU:  result = alu_res;
      WB_SEL_LOAD: result = load_data;
      WB_SEL_PC:   result = pc_next;
      WB_SEL_BYTE: begin
        result = old_dst;
        if (byte_hi) result[15:8] = imm8;
        else         result[7:0]  = imm8;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, register-file write port, decode bypass,
// sticky halt and retired-instruction counter.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  wb_stage_if.slave        mem_if,
  input  logic [AW-1:0]    id_src1,
  input  logic [AW-1:0]    id_src2,
  input  logic [WIDTH-1:0] rf_data1,
  input  logic [WIDTH-1:0] rf_data2,
  output logic             WriteReg,
  output logic [AW-1:0]    DstReg,
  output logic [WIDTH-1:0] DstData,
  output logic [WIDTH-1:0] fwd_data1,
  output logic [WIDTH-1:0] fwd_data2,
  output logic             halted,
  output logic [31:0]      retired
);

  localparam logic [AW-1:0] REG_ZERO_W = AW'(REG_ZERO);

  logic             wb_valid_q, wb_valid_d;
  logic             wb_en_q,    wb_en_d;
  logic [AW-1:0]    wb_dst_q,   wb_dst_d;
  logic [WIDTH-1:0] wb_data_q,  wb_data_d;
  logic             wb_halt_q,  wb_halt_d;
  logic             wb_done_q,  wb_done_d;
  logic             halted_q,   halted_d;
  logic [31:0]      retired_q,  retired_d;
  logic [WIDTH-1:0] mem_result;
  logic             retire;

  wb_result_mux #(.WIDTH(WIDTH)) u_result_mux (
    .sel       (mem_if.mem_sel),
    .byte_hi   (mem_if.mem_byte_hi),
    .alu_res   (mem_if.mem_alu_res),
    .load_data (mem_if.mem_load_data),
    .pc_next   (mem_if.mem_pc_next),
    .old_dst   (mem_if.mem_old_dst),
    .imm8      (mem_if.mem_imm8),
    .result    (mem_result)
  );

  // An entry retires in the first cycle it sits in WB; later stalled cycles are repeats.
  assign retire = wb_valid_q & ~wb_done_q;

  // Next-state for the stage register, halt flag and retire counter.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_en_d    = wb_en_q;
    wb_dst_d   = wb_dst_q;
    wb_data_d  = wb_data_q;
    wb_halt_d  = wb_halt_q;
    wb_done_d  = wb_done_q;
    // HLT takes effect on its own retire edge so the instruction behind it never enters.
    halted_d   = halted_q | (retire & wb_halt_q);
    retired_d  = retired_q + (retire ? 32'd1 : 32'd0);

    if (flush) begin
      wb_valid_d = 1'b0;
      wb_done_d  = 1'b0;
    end else if (halted_d) begin
      wb_valid_d = 1'b0;
    end else if (stall) begin
      wb_done_d = wb_valid_q;
    end else begin
      wb_valid_d = mem_if.mem_valid;
      wb_en_d    = mem_if.mem_wb_en;
      wb_dst_d   = mem_if.mem_dst;
      wb_data_d  = mem_result;
      wb_halt_d  = mem_if.mem_halt;
      wb_done_d  = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_dst_q   <= '0;
      wb_data_q  <= '0;
      wb_halt_q  <= 1'b0;
      wb_done_q  <= 1'b0;
      halted_q   <= 1'b0;
      retired_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      wb_dst_q   <= wb_dst_d;
      wb_data_q  <= wb_data_d;
      wb_halt_q  <= wb_halt_d;
      wb_done_q  <= wb_done_d;
      halted_q   <= halted_d;
      retired_q  <= retired_d;
    end
  end

  assign WriteReg = wb_valid_q & wb_en_q & ~wb_done_q & (wb_dst_q != REG_ZERO_W);
  assign DstReg   = wb_dst_q;
  assign DstData  = wb_data_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

  // Decode read port 1: R0 is zero, otherwise bypass a same-cycle write.
  always_comb begin
    fwd_data1 = rf_data1;
    if (id_src1 == REG_ZERO_W)                 fwd_data1 = '0;
    else if (WriteReg && (DstReg == id_src1))  fwd_data1 = DstData;
  end

  // Decode read port 2: same rule as port 1.
  always_comb begin
    fwd_data2 = rf_data2;
    if (id_src2 == REG_ZERO_W)                 fwd_data2 = '0;
    else if (WriteReg && (DstReg == id_src2))  fwd_data2 = DstData;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 16-bit pipelined CPU, directly upstream of the 16×16 register file write port. It holds the MEM/WB pipeline register with stall/flush control and selects the result: ALU, load data, PC+2, or LLB/LHB byte merge. It drives the register file's write port (WriteReg/DstReg/DstData) exactly once per retired instruction. It also provides write-before-read bypass for the decode-stage read ports, latches HLT, and counts retired instructions.

## Interface
Parameters:
- WIDTH, 16, datapath width
- AW, 4, register index width (register 0 reads as zero and is never written)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- stall  in  1  hold MEM/WB contents
- flush  in  1  invalidate MEM/WB on next edge
- mem_valid  in  1  MEM stage holds an instruction
- mem_wb_en  in  1  instruction writes a register
- mem_dst  in  AW  destination register
- mem_sel  in  2  result select (package encoding)
- mem_byte_hi  in  1  for byte-merge: 1=LHB, 0=LLB
- mem_alu_res, mem_load_data, mem_pc_next, mem_old_dst  in  WIDTH  candidate results / old destination value
- mem_imm8  in  8  byte immediate
- mem_halt  in  1  instruction is HLT
- id_src1, id_src2  in  AW  decode read indices
- rf_data1, rf_data2  in  WIDTH  raw register file read data
- WriteReg  out  1  register file write enable
- DstReg  out  AW  register file write index
- DstData  out  WIDTH  register file write data
- fwd_data1, fwd_data2  out  WIDTH  bypassed operands to decode
- halted  out  1  sticky halt
- retired  out  32  retired-instruction count

## Operation
- Stage registers: wb_valid, wb_en, wb_dst, wb_data (result already muxed at capture), wb_halt, wb_done.
- Result select at capture:
  - SEL_ALU: mem_alu_res
  - SEL_LOAD: mem_load_data
  - SEL_PC: mem_pc_next
  - SEL_BYTE: LLB gives {mem_old_dst[15:8], imm8}; LHB gives {imm8, mem_old_dst[7:0]}
- Capture priority per edge:
  - reset: all stage regs, halted and retired go to 0.
  - flush (overrides stall): wb_valid←0.
  - halted=1: wb_valid←0; nothing retires after HLT.
  - stall: hold all fields; wb_done←wb_valid.
  - otherwise: load from MEM; wb_valid←mem_valid; wb_done←0.
- Write port:
  - WriteReg = wb_valid & wb_en & ~wb_done & (wb_dst≠0).
  - DstReg = wb_dst; DstData = wb_data.
  - A stalled entry therefore writes exactly once.
- Retire: on the edge where wb_valid & ~wb_done, retired increments (wraps at 2^32−1 → 0).
  - If wb_halt is also set, halted←1 on that edge.
  - A halted instruction retires and is counted.
- Bypass:
  - fwd_dataN = DstData when WriteReg & DstReg==id_srcN & id_srcN≠0.
  - Else 0 when id_srcN==0.
  - Else rf_dataN.
- Simultaneous flush and retire-eligible entry: the current entry still writes this cycle (its write is combinational from the stage regs); flush only blocks the incoming one.

## Timing
- Reset values: WriteReg=0, DstReg=0, DstData=0, halted=0, retired=0; fwd_dataN equal to rf_dataN (or 0 for index 0).
- Latency: MEM inputs sampled at edge N.
  - WriteReg is asserted during cycle N→N+1.
  - The register file commits at edge N+1.
- Bypass is combinational: zero latency within the write cycle.
- Back-to-back instructions to the same register: each writes in its own cycle; the later one wins.
- Reset asserted mid-stall discards the held entry without writing.

## Structure
- Package cpu_pkg holds:
  - WB_SEL_ALU=2'b00, WB_SEL_LOAD=2'b01, WB_SEL_PC=2'b10, WB_SEL_BYTE=2'b11
  - REG_ZERO=4'h0
- One sub-module, wb_result_mux: the combinational 4-way select plus byte merge, instantiated once before the stage register.
- Bypass logic is instantiated twice inline; it is not a separate module.

## Test plan
- ALU write: mem_valid=1, wb_en=1, dst=3, SEL_ALU, alu=16'h1234 → next cycle WriteReg=1, DstReg=3, DstData=16'h1234; retired=1 after the following edge.
- Byte merge: old=16'hABCD, imm8=8'h5E.
  - LLB → DstData=16'hAB5E.
  - LHB → DstData=16'h5ECD.
- R0 suppression and bypass:
  - dst=0, alu=16'hFFFF → WriteReg=0, retired still increments.
  - id_src1=0 → fwd_data1=0 regardless of rf_data1.
  - dst=5 writing 16'h00AA with id_src2=5, rf_data2=16'h0011 → fwd_data2=16'h00AA.
- Stall 3 cycles on a dst=7 load of 16'hBEEF → WriteReg high for exactly 1 cycle, retired +1. Flush together with stall → incoming instruction never written.
- HLT followed by two valid ALU instructions → halted=1 after the HLT edge, retired counts the HLT only, no further WriteReg.
- Reset mid-stall and counter wrap:
  - rst=0 while a stalled entry is held → no write; all outputs at their reset values.
  - Counter preloaded near 32'hFFFFFFFF → wraps to 0.
